// File: rtl/ifft_frame_tx.sv
// rtl/ifft_frame_tx.sv - ping-pong frame buffer feeding the IFFT input as gap-free N-sample bursts
// Build option: FRAME_BITREV_EN reads each frame in bit-reversed order.
module ifft_frame_tx #(
    parameter int N   = 256,
    parameter int GAP = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_real,
    input  logic [15:0] s_img,
    output logic        tx_valid,
    output logic [15:0] tx_real,
    output logic [15:0] tx_img,
    output logic        tx_sof,
    output logic [7:0]  frame_cnt
);
    localparam int               LOG2N    = $clog2(N);
    localparam logic [3:0]       GAP_CNT  = 4'(GAP);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP_WAIT} rd_state_t;

    logic [31:0]      mem [2*N];
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N-1:0] rd_idx;
    logic [LOG2N-1:0] rd_addr;
    logic [3:0]       gap_cnt;
    rd_state_t        state;
    logic             accept;
    logic             last_rd;

    assign s_ready = !full[wr_bank];
    assign accept  = s_valid && s_ready;
    assign last_rd = (state == STREAM) && (rd_idx == LAST_IDX);

`ifdef FRAME_BITREV_EN
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < LOG2N; i++) begin
            rd_addr[i] = rd_idx[LOG2N-1-i];
        end
    end
`else
    assign rd_addr = rd_idx;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wr_bank, wr_idx}] <= {s_real, s_img};
        end
    end

    // Set and clear never target the same bank: a full write bank blocks accepts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            if (accept) begin
                wr_idx <= wr_idx + 1'b1;
                if (wr_idx == LAST_IDX) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (last_rd) begin
                full[rd_bank] <= 1'b0;
            end
            if (accept && wr_idx == LAST_IDX) begin
                full[wr_bank] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            tx_valid  <= 1'b0;
            tx_sof    <= 1'b0;
            tx_real   <= '0;
            tx_img    <= '0;
        end else begin
            tx_valid <= (state == STREAM);
            tx_sof   <= (state == STREAM) && (rd_idx == '0);
            if (state == STREAM) begin
                {tx_real, tx_img} <= mem[{rd_bank, rd_addr}];
            end else begin
                {tx_real, tx_img} <= '0;
            end

            case (state)
                IDLE: begin
                    if (full[rd_bank] && gap_cnt == '0) begin
                        state  <= STREAM;
                        rd_idx <= '0;
                    end
                end
                STREAM: begin
                    rd_idx <= rd_idx + 1'b1;
                    if (last_rd) begin
                        rd_bank   <= !rd_bank;
                        frame_cnt <= frame_cnt + 8'd1;
                        if (GAP_CNT != 4'd0) begin
                            state   <= GAP_WAIT;
                            gap_cnt <= GAP_CNT;
                        end else if (!full[~rd_bank]) begin
                            state <= IDLE;
                        end
                    end
                end
                GAP_WAIT: begin
                    // Leaving straight to STREAM keeps the idle run at exactly GAP cycles.
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) begin
                        state <= full[rd_bank] ? STREAM : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
